intersection_phase_scheduler: RTL and testbench

Actuated phase scheduler for a two-road intersection with a pedestrian crossing. It sequences the NS and EW signal heads from vehicle presence sensors and a pedestrian push-button. It enforces minimum/maximum green, yellow, all-red clearance and a protected walk interval. It replaces fixed-time cycling at the top of the traffic-signal datapath and drives the six lamp outputs plus the walk lamp directly.

---
 rtl/intersection_phase_scheduler.sv | 149 ++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
//   Actuated two-road signal controller with a pedestrian walk phase.
//   Sequences NS/EW lamp heads from vehicle presence and a push-button,
//   enforcing min/max green, yellow, all-red clearance and walk dwell.
//
// Ports
//   clk                          rising-edge clock
//   rst                          synchronous active-high reset
//   ns_car, ew_car               vehicle presence (level)
//   ped_req                      pedestrian button
//   ns_red/ns_yellow/ns_green    NS lamp head (one-hot)
//   ew_red/ew_yellow/ew_green    EW lamp head (one-hot)
//   walk                         pedestrian walk lamp
//   ped_pending                  latched, unserved pedestrian request
//
// state      | meaning
// -----------+------------------------------------------------
// NS_GREEN   | NS green, EW red
// NS_YELLOW  | NS yellow, EW red
// RED_A      | all-red clearance after NS
// EW_GREEN   | EW green, NS red
// EW_YELLOW  | EW yellow, NS red
// RED_B      | all-red clearance after EW
// PED_WALK   | walk lamp on, both directions red
module intersection_phase_scheduler #(
    parameter int MIN_GREEN    = 5,
    parameter int MAX_GREEN    = 12,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int WALK_TIME    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ns_car,
    input  logic ew_car,
    input  logic ped_req,
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk,
    output logic ped_pending
);

    localparam int TW = $clog2(MAX_GREEN + 1);

    localparam logic [TW-1:0] T_MIN    = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAX    = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] T_RED    = TW'(ALL_RED_TIME - 1);
    localparam logic [TW-1:0] T_WALK   = TW'(WALK_TIME - 1);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] t;
    // 1: walk was entered from RED_A, so EW gets green next; 0: NS next.
    logic          last_dir;
    logic          enter_walk;

    assign enter_walk = (state_nxt == PED_WALK) && (state != PED_WALK);

    // State register, dwell timer, walk direction and pedestrian latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NS_GREEN;
            t           <= '0;
            last_dir    <= 1'b1;
            ped_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                t <= '0;
            end else if (t != T_MAX) begin
                t <= t + TW'(1);
            end
            if (enter_walk) begin
                last_dir <= (state == RED_A);
            end
            // A press on the walk-entry edge itself survives the clear and
            // is served on the following rotation.
            ped_pending <= ped_req | (ped_pending & ~enter_walk);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            NS_GREEN: begin
                if ((t >= T_MIN) && (ew_car || ped_pending) &&
                    (!ns_car || (t == T_MAX)))
                    state_nxt = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (t == T_YELLOW) state_nxt = RED_A;
            end
            RED_A: begin
                if (t == T_RED) state_nxt = ped_pending ? PED_WALK : EW_GREEN;
            end
            EW_GREEN: begin
                if ((t >= T_MIN) && (ns_car || ped_pending) &&
                    (!ew_car || (t == T_MAX)))
                    state_nxt = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (t == T_YELLOW) state_nxt = RED_B;
            end
            RED_B: begin
                if (t == T_RED) state_nxt = ped_pending ? PED_WALK : NS_GREEN;
            end
            PED_WALK: begin
                if (t == T_WALK) state_nxt = last_dir ? EW_GREEN : NS_GREEN;
            end
            default: state_nxt = NS_GREEN;
        endcase
    end

    // Moore lamp decode.
    always_comb begin
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        walk      = 1'b0;
        case (state)
            NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
            NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
            EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
            EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
            PED_WALK:  walk = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
module tb_intersection_phase_scheduler;

    logic clk = 1'b0;
    logic rst, ns_car, ew_car, ped_req;
    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending;

    int checks = 0;
    int errors = 0;

    // Lamp codes: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    localparam logic [6:0] L_NSG  = 7'b001_100_0;
    localparam logic [6:0] L_NSY  = 7'b010_100_0;
    localparam logic [6:0] L_ARED = 7'b100_100_0;
    localparam logic [6:0] L_EWG  = 7'b100_001_0;
    localparam logic [6:0] L_EWY  = 7'b100_010_0;
    localparam logic [6:0] L_WALK = 7'b100_100_1;
    localparam int PED_LIMIT = 2*12 + 2*2 + 2*1;

    typedef struct {
        logic       r;
        logic       n;
        logic       e;
        logic       p;
        logic [6:0] lamps;
        logic       pp;
    } vec_t;

    vec_t vq[$];

    intersection_phase_scheduler dut (
        .clk(clk), .rst(rst), .ns_car(ns_car), .ew_car(ew_car), .ped_req(ped_req),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic n, input logic e, input logic p);
        rst = r; ns_car = n; ew_car = e; ped_req = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] lamps, input logic pp);
        logic [7:0] act, exp;
        act = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending};
        exp = {lamps, pp};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic n, input logic e, input logic p,
                       input logic [6:0] lamps, input logic pp, input int count);
        vec_t v;
        v.r = r; v.n = n; v.e = e; v.p = p; v.lamps = lamps; v.pp = pp;
        for (int i = 0; i < count; i++) vq.push_back(v);
    endtask

    task automatic run_seq(input string name);
        foreach (vq[i]) begin
            step(vq[i].r, vq[i].n, vq[i].e, vq[i].p);
            check($sformatf("%s[%0d]", name, i), vq[i].lamps, vq[i].pp);
        end
        vq.delete();
    endtask

    initial begin
        rst = 1'b1; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;

        // Reset and rest: idle controller stays in NS green.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset", L_NSG, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 0);
            check($sformatf("rest[%0d]", i), L_NSG, 1'b0);
        end

        // Minimum green, then an EW-green pedestrian press served from RED_B.
        add(1, 0, 1, 0, L_NSG,  0, 1);
        add(0, 0, 1, 0, L_NSG,  0, 4);
        add(0, 0, 1, 0, L_NSY,  0, 2);
        add(0, 0, 1, 0, L_ARED, 0, 1);
        add(0, 0, 1, 0, L_EWG,  0, 8);
        add(0, 0, 1, 1, L_EWG,  1, 1);
        add(0, 0, 1, 0, L_EWG,  1, 3);
        add(0, 0, 1, 0, L_EWY,  1, 2);
        add(0, 0, 1, 0, L_ARED, 1, 1);
        add(0, 0, 1, 0, L_WALK, 0, 4);
        add(0, 0, 1, 0, L_NSG,  0, 2);
        run_seq("min_green_ped");

        // Max-green cap with demand on both roads.
        add(1, 1, 1, 0, L_NSG,  0, 1);
        add(0, 1, 1, 0, L_NSG,  0, 11);
        add(0, 1, 1, 0, L_NSY,  0, 2);
        add(0, 1, 1, 0, L_ARED, 0, 1);
        add(0, 1, 1, 0, L_EWG,  0, 12);
        add(0, 1, 1, 0, L_EWY,  0, 2);
        add(0, 1, 1, 0, L_ARED, 0, 1);
        add(0, 1, 1, 0, L_NSG,  0, 12);
        add(0, 1, 1, 0, L_NSY,  0, 2);
        run_seq("max_green");

        // Walk from RED_A returns to EW green; a press on the walk-entry
        // edge survives and is served again after EW green via RED_B.
        add(1, 0, 0, 0, L_NSG,  0, 1);
        add(0, 0, 0, 1, L_NSG,  1, 1);
        add(0, 0, 0, 0, L_NSG,  1, 3);
        add(0, 0, 0, 0, L_NSY,  1, 2);
        add(0, 0, 0, 0, L_ARED, 1, 1);
        add(0, 0, 0, 1, L_WALK, 1, 1);
        add(0, 0, 0, 0, L_WALK, 1, 3);
        add(0, 0, 0, 0, L_EWG,  1, 5);
        add(0, 0, 0, 0, L_EWY,  1, 2);
        add(0, 0, 0, 0, L_ARED, 1, 1);
        add(0, 0, 0, 0, L_WALK, 0, 4);
        add(0, 0, 0, 0, L_NSG,  0, 2);
        run_seq("walk_reentry");

        // Reset mid-walk with the button held discards the request.
        add(1, 0, 0, 0, L_NSG,  0, 1);
        add(0, 0, 0, 1, L_NSG,  1, 1);
        add(0, 0, 0, 0, L_NSG,  1, 3);
        add(0, 0, 0, 0, L_NSY,  1, 2);
        add(0, 0, 0, 0, L_ARED, 1, 1);
        add(0, 0, 0, 0, L_WALK, 0, 1);
        add(1, 0, 0, 1, L_NSG,  0, 1);
        add(0, 0, 0, 0, L_NSG,  0, 8);
        run_seq("reset_walk");

        // Random safety scoreboard.
        begin
            bit outstanding = 0;
            bit prev_walk;
            int age = 0;
            logic [3:0] ok;
            step(1, 0, 0, 0);
            prev_walk = walk;
            for (int i = 0; i < 5000; i++) begin
                logic p;
                p = ($urandom_range(0, 15) == 0);
                step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p);
                ok[0] = $onehot({ns_red, ns_yellow, ns_green});
                ok[1] = $onehot({ew_red, ew_yellow, ew_green});
                ok[2] = ns_red | ew_red;
                ok[3] = !walk || (ns_red && ew_red);
                checks++;
                if (ok !== 4'b1111) begin
                    errors++;
                    $display("FAIL safety @%0t: got flags %b expected 1111", $time, ok);
                end
                if (outstanding) age++;
                if (walk && !prev_walk && outstanding) begin
                    checks++;
                    if (age > PED_LIMIT) begin
                        errors++;
                        $display("FAIL ped_latency: got %0d cycles expected <= %0d", age, PED_LIMIT);
                    end
                    outstanding = 0;
                end else if (outstanding && age > PED_LIMIT) begin
                    checks++;
                    errors++;
                    $display("FAIL ped_latency: got >%0d cycles without walk expected <= %0d", age, PED_LIMIT);
                    outstanding = 0;
                end
                if (p && !outstanding) begin
                    outstanding = 1;
                    age = 1;
                    if (walk && !prev_walk) age = 0;
                end
                prev_walk = walk;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
